// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection (jr / jump / branch / sequential)
// with a circular return-address stack that predicts jr targets.
module pc_sequencer #(
   parameter int unsigned       ADDR_W    = 32,
   parameter bit                WORD_ADDR = 1'b1,
   parameter int unsigned       RAS_DEPTH = 4,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic [31:0]       inst,
   input  logic              jump,
   input  logic              jal,
   input  logic              jr,
   input  logic              branch_taken,
   input  logic [15:0]       branch_off,
   input  logic [ADDR_W-1:0] reg_target,
   output logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] pc_inc,
   output logic [ADDR_W-1:0] ras_top,
   output logic              ras_empty,
   output logic              ras_full,
   output logic              ret_mispredict
);

   localparam int unsigned       PTR_W = $clog2(RAS_DEPTH);
   localparam int unsigned       CNT_W = $clog2(RAS_DEPTH + 1);
   localparam logic [ADDR_W-1:0] INC   = WORD_ADDR ? ADDR_W'(1) : ADDR_W'(4);
   localparam logic [CNT_W-1:0]  FULL  = CNT_W'(RAS_DEPTH);

   logic [ADDR_W-1:0] stack [RAS_DEPTH];
   logic [PTR_W-1:0]  ptr;
   logic [CNT_W-1:0]  cnt;

   logic [PTR_W-1:0]  ptr_nxt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic [ADDR_W-1:0] pc_nxt;
   logic              push;
   logic              mis_nxt;

   logic [31:0]       pc32;
   logic [ADDR_W-1:0] jump_tgt;
   logic [ADDR_W-1:0] boff;
   logic [ADDR_W-1:0] br_tgt;
   logic              unused_bits;

   assign pc_inc  = pc + INC;
   assign ras_top = (cnt == '0) ? '0 : stack[ptr - PTR_W'(1)];

   // Work in a 32-bit view of the PC so narrow ADDR_W needs no special slicing
   assign pc32        = 32'(pc);
   assign unused_bits = ^{inst[31:26], pc32};

   always_comb begin
      jump_tgt = WORD_ADDR ? ADDR_W'({pc32[31:26], inst[25:0]})
                           : ADDR_W'({pc32[31:28], inst[25:0], 2'b00});
      boff     = {{(ADDR_W-16){branch_off[15]}}, branch_off};
      br_tgt   = WORD_ADDR ? (pc_inc + boff) : (pc_inc + (boff << 2));
   end

   // Next-state: jr > (jump|jal) > branch > sequential
   always_comb begin
      pc_nxt  = pc;
      ptr_nxt = ptr;
      cnt_nxt = cnt;
      push    = 1'b0;
      mis_nxt = 1'b0;
      if (!stall) begin
         if (jr) begin
            pc_nxt  = reg_target;
            mis_nxt = (cnt == '0) || (reg_target != ras_top);
            if (cnt != '0) begin
               ptr_nxt = ptr - PTR_W'(1);
               cnt_nxt = cnt - CNT_W'(1);
            end
         end else if (jump || jal) begin
            pc_nxt = jump_tgt;
            if (jal) begin
               push    = 1'b1;
               ptr_nxt = ptr + PTR_W'(1);
               if (cnt != FULL) begin
                  cnt_nxt = cnt + CNT_W'(1);
               end
            end
         end else if (branch_taken) begin
            pc_nxt = br_tgt;
         end else begin
            pc_nxt = pc_inc;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc             <= RESET_PC;
         ptr            <= '0;
         cnt            <= '0;
         ras_empty      <= 1'b1;
         ras_full       <= 1'b0;
         ret_mispredict <= 1'b0;
      end else begin
         pc             <= pc_nxt;
         ptr            <= ptr_nxt;
         cnt            <= cnt_nxt;
         ras_empty      <= (cnt_nxt == '0);
         ras_full       <= (cnt_nxt == FULL);
         ret_mispredict <= mis_nxt;
      end
   end

   // Entries need no reset; a push into a full stack overwrites the oldest slot
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         stack[ptr] <= pc_inc;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized bench for pc_sequencer: word- and byte-addressed instances driven
// in lockstep and compared every cycle against a list-based return-stack model.
module tb_pc_sequencer;

   logic        clk = 1'b0;
   logic        reset, stall, jump, jal, jr, branch_taken;
   logic [31:0] inst, reg_target;
   logic [15:0] branch_off;

   logic [31:0] pc_w, pc_inc_w, ras_top_w;
   logic        ras_empty_w, ras_full_w, mis_w;
   logic [31:0] pc_b, pc_inc_b, ras_top_b;
   logic        ras_empty_b, ras_full_b, mis_b;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model state: index 0 = word-addressed, 1 = byte-addressed
   logic [31:0] m_pc  [2];
   logic [31:0] m_stk [2][4];
   int          m_sz  [2];
   bit          m_mis [2];

   always #5 clk = ~clk;

   pc_sequencer dut_w (
      .clk(clk), .reset(reset), .stall(stall), .inst(inst), .jump(jump), .jal(jal),
      .jr(jr), .branch_taken(branch_taken), .branch_off(branch_off), .reg_target(reg_target),
      .pc(pc_w), .pc_inc(pc_inc_w), .ras_top(ras_top_w), .ras_empty(ras_empty_w),
      .ras_full(ras_full_w), .ret_mispredict(mis_w)
   );

   pc_sequencer #(.WORD_ADDR(1'b0)) dut_b (
      .clk(clk), .reset(reset), .stall(stall), .inst(inst), .jump(jump), .jal(jal),
      .jr(jr), .branch_taken(branch_taken), .branch_off(branch_off), .reg_target(reg_target),
      .pc(pc_b), .pc_inc(pc_inc_b), .ras_top(ras_top_b), .ras_empty(ras_empty_b),
      .ras_full(ras_full_b), .ret_mispredict(mis_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_top(input int k);
      return (m_sz[k] > 0) ? m_stk[k][m_sz[k]-1] : 32'h0;
   endfunction

   task automatic model_step(input int k);
      logic [31:0] pinc, tgt, off;
      pinc = m_pc[k] + ((k == 0) ? 32'd1 : 32'd4);
      if (reset) begin
         m_pc[k]  = 32'h0;
         m_sz[k]  = 0;
         m_mis[k] = 1'b0;
      end else if (stall) begin
         m_mis[k] = 1'b0;
      end else begin
         m_mis[k] = 1'b0;
         if (jr) begin
            m_mis[k] = (m_sz[k] == 0) || (reg_target != m_top(k));
            if (m_sz[k] > 0) m_sz[k]--;
            m_pc[k] = reg_target;
         end else if (jump || jal) begin
            if (k == 0) tgt = (m_pc[k] & 32'hFC00_0000) | 32'(inst[25:0]);
            else        tgt = (m_pc[k] & 32'hF000_0000) | 32'({inst[25:0], 2'b00});
            if (jal) begin
               if (m_sz[k] == 4) begin
                  for (int i = 0; i < 3; i++) m_stk[k][i] = m_stk[k][i+1];
                  m_stk[k][3] = pinc;
               end else begin
                  m_stk[k][m_sz[k]] = pinc;
                  m_sz[k]++;
               end
            end
            m_pc[k] = tgt;
         end else if (branch_taken) begin
            off = {{16{branch_off[15]}}, branch_off};
            m_pc[k] = (k == 0) ? pinc + off : pinc + (off << 2);
         end else begin
            m_pc[k] = pinc;
         end
      end
   endtask

   task automatic compare_all();
      check("pc_w",        pc_w,               m_pc[0]);
      check("pc_inc_w",    pc_inc_w,           m_pc[0] + 32'd1);
      check("ras_top_w",   ras_top_w,          m_top(0));
      check("ras_empty_w", 32'(ras_empty_w),   32'(m_sz[0] == 0));
      check("ras_full_w",  32'(ras_full_w),    32'(m_sz[0] == 4));
      check("mispred_w",   32'(mis_w),         32'(m_mis[0]));
      check("pc_b",        pc_b,               m_pc[1]);
      check("pc_inc_b",    pc_inc_b,           m_pc[1] + 32'd4);
      check("ras_top_b",   ras_top_b,          m_top(1));
      check("ras_empty_b", 32'(ras_empty_b),   32'(m_sz[1] == 0));
      check("ras_full_b",  32'(ras_full_b),    32'(m_sz[1] == 4));
      check("mispred_b",   32'(mis_b),         32'(m_mis[1]));
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   task automatic ctl(input bit r, input bit s, input bit j_r, input bit j_al,
                      input bit j_mp, input bit b_t);
      reset = r; stall = s; jr = j_r; jal = j_al; jump = j_mp; branch_taken = b_t;
   endtask

   initial begin
      inst = 32'h0; reg_target = 32'h0; branch_off = 16'h0;
      ctl(1, 0, 0, 0, 0, 0);
      tick();
      check("reset_pc", pc_w, 32'h0);
      check("reset_empty", 32'(ras_empty_w), 32'h1);

      // Sequential advance, then stall hold
      ctl(0, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 3; i++) begin
         tick();
         check("seq_pc", pc_w, 32'(i));
      end
      ctl(0, 1, 1, 1, 1, 1);
      tick(); tick();
      check("stall_hold", pc_w, 32'h3);

      // Jump keeps upper PC bits
      ctl(0, 0, 1, 0, 0, 0); reg_target = 32'h0400_0010; tick();
      ctl(0, 0, 0, 0, 1, 0); inst = 32'hFC00_0123; tick();
      check("jump_tgt", pc_w, 32'h0400_0123);

      // Negative branch in byte mode
      ctl(0, 0, 1, 0, 0, 0); reg_target = 32'h1000_0040; tick();
      ctl(0, 0, 0, 0, 0, 1); branch_off = 16'hFFFE; tick();
      check("branch_back", pc_b, 32'h1000_003C);

      // jal then matching jr
      ctl(1, 0, 0, 0, 0, 0); tick();
      ctl(0, 0, 1, 0, 0, 0); reg_target = 32'h20; tick();
      ctl(0, 0, 0, 1, 0, 0); inst = 32'h40; tick();
      check("jal_top", ras_top_w, 32'h21);
      ctl(0, 0, 1, 0, 0, 0); reg_target = 32'h21; tick();
      check("ret_ok", 32'(mis_w), 32'h0);
      check("ret_empty", 32'(ras_empty_w), 32'h1);

      // Overflow: five calls into a four-deep stack
      ctl(1, 0, 0, 0, 0, 0); tick();
      for (int i = 1; i <= 5; i++) begin
         ctl(0, 0, 0, 0, 1, 0); inst = 32'(i * 16); tick();
         ctl(0, 0, 0, 1, 0, 0); inst = 32'h100; tick();
      end
      check("ovf_full", 32'(ras_full_w), 32'h1);
      for (int i = 5; i >= 2; i--) begin
         check("pop_top", ras_top_w, 32'(i * 16 + 1));
         ctl(0, 0, 1, 0, 0, 0); reg_target = 32'(i * 16 + 1); tick();
         check("pop_mis", 32'(mis_w), 32'h0);
      end
      check("pop_empty", 32'(ras_empty_w), 32'h1);
      ctl(0, 0, 1, 0, 0, 0); reg_target = 32'h11; tick();
      check("empty_mis", 32'(mis_w), 32'h1);
      ctl(0, 0, 0, 0, 0, 0); tick();
      check("mis_pulse", 32'(mis_w), 32'h0);

      // jr beats jal; PC wrap
      ctl(0, 0, 1, 1, 0, 0); reg_target = 32'h80; tick();
      check("jr_jal_pc", pc_w, 32'h80);
      check("jr_jal_nopush", 32'(ras_empty_w), 32'h1);
      ctl(0, 0, 1, 0, 0, 0); reg_target = 32'hFFFF_FFFF; tick();
      ctl(0, 0, 0, 0, 0, 0); tick();
      check("pc_wrap", pc_w, 32'h0);

      // Random traffic
      for (int n = 0; n < 2000; n++) begin
         int r;
         r = int'($urandom_range(0, 9));
         reset        = ($urandom_range(0, 99) < 2);
         stall        = ($urandom_range(0, 99) < 15);
         jr           = (r == 0) || (r == 1);
         jal          = (r == 1) || (r == 2) || (r == 3);
         jump         = (r == 4) || ((r == 3) && $urandom_range(0, 1) == 1);
         branch_taken = (r == 5) || ($urandom_range(0, 7) == 0);
         inst         = $urandom;
         branch_off   = 16'($urandom);
         reg_target   = ($urandom_range(0, 1) == 1) ? m_top(0) : $urandom;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: PC width, legal range 28..32.
REQ-002 SHALL have parameter WORD_ADDR, default 1: 1 = word-addressed PC (increment 1), 0 = byte-addressed PC (increment 4).
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-address-stack entries, power of two, 2..16.
REQ-004 SHALL have parameter RESET_PC, default 0: PC value loaded at reset.
REQ-005 SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have the port stall, input, 1 bit: hold the PC and the RAS.
REQ-008 SHALL have the port inst, input, 32 bits: the current instruction; bits 25:0 are the jump index.
REQ-009 SHALL have the port jump, input, 1 bit: J-type jump.
REQ-010 SHALL have the port jal, input, 1 bit: jump-and-link.
REQ-011 SHALL have the port jr, input, 1 bit: jump to register.
REQ-012 SHALL have the port branch_taken, input, 1 bit: conditional branch resolved taken.
REQ-013 SHALL have the port branch_off, input, 16 bits: signed branch offset, in words.
REQ-014 SHALL have the port reg_target, input, ADDR_W bits: jr target from the register file.
REQ-015 SHALL have the port pc, output, ADDR_W bits: the registered current PC.
REQ-016 SHALL have the port pc_inc, output, ADDR_W bits: combinational pc + INC, where INC = 1 if WORD_ADDR else 4.
REQ-017 SHALL have the port ras_top, output, ADDR_W bits: top RAS entry, or 0 when the RAS is empty.
REQ-018 SHALL have the port ras_empty, output, 1 bit: RAS holds no entries.
REQ-019 SHALL have the port ras_full, output, 1 bit: RAS holds RAS_DEPTH entries.
REQ-020 SHALL have the port ret_mispredict, output, 1 bit: registered flag, high for one cycle after a jr whose reg_target differed from ras_top or found the RAS empty.

Function
REQ-021 pc SHALL update only on an edge with reset=0 and stall=0; the next-PC priority order SHALL be jr > (jump|jal) > branch_taken > sequential.
REQ-022 Sequential next PC SHALL be pc_inc, wrapping modulo 2^ADDR_W.
REQ-023 With WORD_ADDR=1, the jump target SHALL be {pc[ADDR_W-1:26], inst[25:0]}.
REQ-024 With WORD_ADDR=0, the jump target SHALL be {pc[ADDR_W-1:28], inst[25:0], 2'b00}.
REQ-025 The branch target SHALL be pc_inc + sext(branch_off), shifted left by 2 when WORD_ADDR=0, and SHALL wrap modulo 2^ADDR_W.
REQ-026 The jr target SHALL be reg_target, used unmodified.
REQ-027 jal SHALL take the jump target and push pc_inc onto the RAS in the same edge.
REQ-028 A push when the RAS is full SHALL overwrite the oldest entry (circular), leave the count at RAS_DEPTH, and keep ras_full=1.
REQ-029 jr SHALL pop the RAS and SHALL set ret_mispredict on the next cycle when reg_target != ras_top or the RAS is empty.
REQ-030 A pop when the RAS is empty SHALL leave the count at 0.
REQ-031 When jr and jal are both asserted, jr SHALL win: pop only, no push.
REQ-032 When jump and jal are both asserted, the behaviour SHALL be that of jal.
REQ-033 With stall=1, pc, the RAS contents, the RAS pointer and the RAS count SHALL be held, and ret_mispredict SHALL clear to 0.
REQ-034 ret_mispredict SHALL be 0 on every cycle not following an unstalled jr that met the mispredict condition.
REQ-035 The RAS count, pointer, ras_empty and ras_full SHALL be registered state; ras_top SHALL be read combinationally from the stack.

Reset
REQ-036 On reset=1 at an edge: pc = RESET_PC, RAS count = 0, pointer = 0, ret_mispredict = 0, ras_empty = 1, ras_full = 0; RAS entry contents are don't-care.
REQ-037 reset SHALL override stall and every control input.
REQ-038 After reset, the first unstalled edge SHALL advance pc.
REQ-039 Reset asserted mid-sequence (pending pop or mispredict) SHALL discard all RAS state and any pending flag.

Verification
REQ-040 Bench SHALL cover, with defaults: reset then 3 unstalled cycles -> pc 0,1,2,3; stall high for 2 cycles at pc=3 -> pc stays 3.
REQ-041 Bench SHALL cover: pc=0x0400_0010, jump, inst[25:0]=0x0000123 -> pc=0x0400_0123.
REQ-042 Bench SHALL cover, with WORD_ADDR=0: pc=0x1000_0040, branch_taken, branch_off=0xFFFE -> pc=0x1000_003C.
REQ-043 Bench SHALL cover: jal at pc=0x20, then jr with reg_target=0x21 -> ras_top=0x21 before the jr, ret_mispredict=0, ras_empty=1 afterwards.
REQ-044 Bench SHALL cover: 5 jals from pc values 0x10, 0x20, 0x30, 0x40, 0x50 (depth 4) -> ras_full=1, pops return 0x51, 0x41, 0x31, 0x21, then the RAS is empty; jr reg_target=0x11 on the empty RAS -> ret_mispredict=1 for one cycle.
REQ-045 Bench SHALL cover: jr and jal asserted together with reg_target=0x80 -> pc=0x80, no push; pc=0xFFFF_FFFF sequential -> pc=0.
